// File: rtl/ppbuff_pkg.sv
// Shared types for the ping-pong buffer slot scheduler: FSM state encoding,
// buffer command encoding and the two-way enq/deq arbitration helper.
package ppbuff_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_PUSH  = 2'd1,
        CMD_POP   = 2'd2,
        CMD_FLUSH = 2'd3
    } cmd_e;

    typedef struct packed {
        logic enq_grant;
        logic deq_grant;
        logic contested;
    } grant_t;

    // prio = 0 favours enq when both sides compete; a lone candidate always wins.
    function automatic grant_t arbitrate(input logic enq_cand,
                                        input logic deq_cand,
                                        input logic prio);
        grant_t g;
        g.contested = enq_cand & deq_cand;
        g.enq_grant = enq_cand & (~deq_cand | ~prio);
        g.deq_grant = deq_cand & (~enq_cand | prio);
        return g;
    endfunction

endpackage

// File: rtl/ppbuff_sched_if.sv
// Producer/consumer/buffer-command bundle for ppbuff_sched; the scheduler is
// the slave side, the environment driving requests is the master side.
interface ppbuff_sched_if #(
    parameter int DP = 8,
    parameter int AW = $clog2(DP)
);
    logic          enq_valid;
    logic          enq_ready;
    logic [AW-1:0] enq_index;
    logic          deq_valid;
    logic [AW-1:0] deq_index;
    logic          deq_ready;
    logic          deq_ack;
    logic          flush_req;
    logic          flush_busy;
    logic          buf_push;
    logic          buf_pop;
    logic          buf_flush;
    logic [AW-1:0] buf_index;
    logic [DP-1:0] occ;
    logic [AW:0]   count;

    modport master (
        output enq_valid, deq_ready, flush_req,
        input  enq_ready, enq_index, deq_valid, deq_index, deq_ack,
        input  flush_busy, buf_push, buf_pop, buf_flush, buf_index, occ, count
    );

    modport slave (
        input  enq_valid, deq_ready, flush_req,
        output enq_ready, enq_index, deq_valid, deq_index, deq_ack,
        output flush_busy, buf_push, buf_pop, buf_flush, buf_index, occ, count
    );
endinterface

// File: rtl/ppbuff_freesel.sv
// Lowest-index free slot finder: returns the position of the lowest zero bit
// in the occupancy mask, with found_o low when every slot is taken.
module ppbuff_freesel #(
    parameter  int DP = 8,
    localparam int AW = $clog2(DP)
) (
    input  logic [DP-1:0] mask_i,
    output logic [AW-1:0] index_o,
    output logic          found_o
);

    // Scanning downward lets the lowest zero overwrite any higher one.
    always_comb begin
        index_o = '0;
        found_o = 1'b0;
        for (int i = DP - 1; i >= 0; i--) begin
            if (!mask_i[i]) begin
                index_o = AW'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ppbuff_sched.sv
// Slot scheduler: hands out free buffer slots, releases them oldest-first via
// an age-order ring, and walks every slot when a flush is requested.
module ppbuff_sched
    import ppbuff_pkg::*;
#(
    parameter  int DP = 8,
    localparam int AW = $clog2(DP)
) (
    input  logic           CLK,
    input  logic           RST,
    ppbuff_sched_if.slave  bus
);

    localparam logic [AW-1:0] LAST_SLOT = AW'(DP - 1);
    localparam logic [AW:0]   ONE_CNT   = (AW + 1)'(1);

    state_e        state_q, state_d;
    logic [AW-1:0] fcnt_q, fcnt_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [DP-1:0] occ_q, occ_d;
    logic [AW:0]   count_q, count_d;
    logic          prio_q, prio_d;
    logic [AW-1:0] ring_q [DP];

    logic [AW-1:0] free_idx;
    logic          free_found;
    logic          run;
    logic          deq_valid_w;
    logic          enq_cand;
    logic          deq_cand;
    grant_t        grant;
    logic [AW-1:0] head_slot;
    cmd_e          cmd;

    ppbuff_freesel #(.DP(DP)) u_freesel (
        .mask_i  (occ_q),
        .index_o (free_idx),
        .found_o (free_found)
    );

    // A pending flush request blocks both sides in the cycle it is raised.
    always_comb begin
        run         = (state_q == ST_RUN);
        deq_valid_w = run && (count_q != '0);
        enq_cand    = run && !bus.flush_req && bus.enq_valid && free_found;
        deq_cand    = run && !bus.flush_req && deq_valid_w && bus.deq_ready;
        grant       = arbitrate(enq_cand, deq_cand, prio_q);
        head_slot   = ring_q[head_q];
    end

    always_comb begin
        cmd = CMD_NONE;
        if (!run) begin
            cmd = CMD_FLUSH;
        end else if (grant.enq_grant) begin
            cmd = CMD_PUSH;
        end else if (grant.deq_grant) begin
            cmd = CMD_POP;
        end
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        count_d = count_q;
        prio_d  = prio_q;
        unique case (state_q)
            ST_RUN: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                end else if (grant.enq_grant) begin
                    occ_d[free_idx] = 1'b1;
                    tail_d          = tail_q + 1'b1;
                    count_d         = count_q + ONE_CNT;
                    if (grant.contested) prio_d = ~prio_q;
                end else if (grant.deq_grant) begin
                    occ_d[head_slot] = 1'b0;
                    head_d           = head_q + 1'b1;
                    count_d          = count_q - ONE_CNT;
                    if (grant.contested) prio_d = ~prio_q;
                end
            end
            ST_FLUSH: begin
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == LAST_SLOT) begin
                    state_d = ST_RUN;
                    occ_d   = '0;
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            count_q <= '0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            count_q <= count_d;
            prio_q  <= prio_d;
        end
    end

    // Ring contents are only meaningful between head and tail, so no reset.
    always_ff @(posedge CLK) begin
        if (grant.enq_grant && !RST) begin
            ring_q[tail_q] <= free_idx;
        end
    end

    always_comb begin
        bus.enq_ready  = grant.enq_grant;
        bus.enq_index  = free_idx;
        bus.deq_valid  = deq_valid_w;
        bus.deq_index  = head_slot;
        bus.deq_ack    = grant.deq_grant;
        bus.flush_busy = (state_q == ST_FLUSH);
        bus.buf_push   = (cmd == CMD_PUSH);
        bus.buf_pop    = (cmd == CMD_POP);
        bus.buf_flush  = (cmd == CMD_FLUSH);
        bus.occ        = occ_q;
        bus.count      = count_q;
        unique case (cmd)
            CMD_PUSH:  bus.buf_index = free_idx;
            CMD_POP:   bus.buf_index = head_slot;
            CMD_FLUSH: bus.buf_index = fcnt_q;
            default:   bus.buf_index = '0;
        endcase
    end

endmodule
